// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute control FSM for the program counter block.
// The optional retired-instruction counter is enabled by defining PC_SEQ_PERF_EN.
// Latency: each instruction takes 1 + W + 1 cycles (W = ack wait cycles, min 2).
// Backpressure: holds FETCH with imem_req high until imem_ack; faults and halts after TIMEOUT cycles.
module pc_sequencer #(
  parameter int IMM_W   = 5,
  parameter int TIMEOUT = 8,
  parameter int PERF_W  = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  output logic              o_imem_req,
  input  logic              i_imem_ack,
  input  logic [1:0]        i_op_class,
  input  logic [IMM_W-1:0]  i_imm_in,
  input  logic              i_skip_cond,
  output logic              o_ir_load,
  output logic              o_reg_write,
  output logic              o_pc_write,
  output logic [1:0]        o_sig_pc_src,
  output logic [IMM_W-1:0]  o_j_type_immediate,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_fault,
  output logic [PERF_W-1:0] o_instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_SKIP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] SRC_DFT  = 2'b00;
  localparam logic [1:0] SRC_JMP  = 2'b01;
  localparam logic [1:0] SRC_SKIP = 2'b10;

  // Last FETCH cycle index; an ack on this cycle is still accepted.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [IMM_W-1:0] r_jimm;
  logic [7:0]       r_wait_cnt;
  logic             r_fault;

  // State sequencing, instruction latch, fetch-wait counter and sticky fault.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_ALU;
      r_jimm     <= '0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state <= S_FETCH;
            r_fault <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            r_op       <= i_op_class;
            // Jump offset is registered at capture so it is stable throughout EXEC.
            if (i_op_class == OP_JMP) r_jimm <= i_imm_in;
            r_wait_cnt <= '0;
            r_state    <= S_EXEC;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          r_state <= (r_op == OP_HALT) ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          if (i_run) begin
            r_state <= S_FETCH;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decoded from registered state and latched class, so reset drops them at once.
  always_comb begin
    o_imem_req   = 1'b0;
    o_ir_load    = 1'b0;
    o_reg_write  = 1'b0;
    o_pc_write   = 1'b0;
    o_sig_pc_src = SRC_DFT;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_load  = i_imem_ack;
      end
      S_EXEC: begin
        case (r_op)
          OP_ALU: begin
            o_reg_write = 1'b1;
            o_pc_write  = 1'b1;
          end
          OP_JMP: begin
            o_pc_write   = 1'b1;
            o_sig_pc_src = SRC_JMP;
          end
          OP_SKIP: begin
            o_pc_write   = 1'b1;
            o_sig_pc_src = i_skip_cond ? SRC_SKIP : SRC_DFT;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_j_type_immediate = r_jimm;
  assign o_busy             = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign o_halted           = (r_state == S_HALT);
  assign o_fault            = r_fault;

`ifdef PC_SEQ_PERF_EN
  logic [PERF_W-1:0] r_instr_count;

  // Saturating count of retired non-HALT instructions.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_instr_count <= '0;
    end else if ((r_state == S_EXEC) && (r_op != OP_HALT) && (r_instr_count != '1)) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign o_instr_count = r_instr_count;
`else
  assign o_instr_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small modulo-32 PC block model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Build with PC_SEQ_PERF_EN defined to exercise the saturating counter at PERF_W=2.
module tb_pc_sequencer;

`ifdef PC_SEQ_PERF_EN
  localparam int PERF_W = 2;
  localparam int EXP_CNT1 = 1;
  localparam int EXP_CNT5 = 3;
`else
  localparam int PERF_W = 16;
  localparam int EXP_CNT1 = 0;
  localparam int EXP_CNT5 = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              imem_ack = 1'b0;
  logic [1:0]        op_class = 2'b00;
  logic [4:0]        imm_in = 5'd0;
  logic              skip_cond = 1'b0;
  logic              imem_req, ir_load, reg_write, pc_write, busy, halted, fault;
  logic [1:0]        pc_src;
  logic [4:0]        jimm;
  logic [PERF_W-1:0] instr_count;
  logic [4:0]        pc = 5'd0;
  int                checks = 0;
  int                errors = 0;

  pc_sequencer #(.IMM_W(5), .TIMEOUT(8), .PERF_W(PERF_W)) dut (
    .i_clock(clk), .i_reset(rst), .i_run(run),
    .o_imem_req(imem_req), .i_imem_ack(imem_ack), .i_op_class(op_class),
    .i_imm_in(imm_in), .i_skip_cond(skip_cond),
    .o_ir_load(ir_load), .o_reg_write(reg_write), .o_pc_write(pc_write),
    .o_sig_pc_src(pc_src), .o_j_type_immediate(jimm),
    .o_busy(busy), .o_halted(halted), .o_fault(fault), .o_instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // PC block model: modulo-32 add selected by source when pc_write is high.
  always @(posedge clk) begin
    if (pc_write) begin
      case (pc_src)
        2'b01:   pc <= pc + jimm;
        2'b10:   pc <= pc + 5'd2;
        default: pc <= pc + 5'd1;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_state busy %0b halted %0b want 0 0", busy, halted); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b want 0", fault); end
    checks++; if (jimm !== 5'd0 || pc_src !== 2'b00) begin errors++; $display("FAIL rst_pc_out jimm %0d src %0b want 0 00", jimm, pc_src); end
    checks++; if (instr_count !== '0) begin errors++; $display("FAIL rst_count got %0d want 0", instr_count); end
    step();
    rst = 1'b0;
    // Idle without run: nothing moves, ack ignored.
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || ir_load !== 1'b0) begin errors++; $display("FAIL idle_hold busy %0b req %0b ld %0b want 0 0 0", busy, imem_req, ir_load); end
    step();
  endtask

  task automatic test_alu();
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1'b1; op_class = 2'b00;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || ir_load !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL alu_fetch req %0b ld %0b busy %0b want 1 1 1", imem_req, ir_load, busy); end
      checks++; if (reg_write !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL alu_fetch_strobes wr %0b pcw %0b want 0 0", reg_write, pc_write); end
      step();
      imem_ack = 1'b0;
      @(negedge clk);
      checks++; if (reg_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00) begin errors++; $display("FAIL alu_exec wr %0b pcw %0b src %0b want 1 1 00", reg_write, pc_write, pc_src); end
      checks++; if (imem_req !== 1'b0 || ir_load !== 1'b0) begin errors++; $display("FAIL alu_exec_req req %0b ld %0b want 0 0", imem_req, ir_load); end
      step();
      checks++; if (pc !== 5'(i + 1)) begin errors++; $display("FAIL alu_pc got %0d want %0d", pc, i + 1); end
      @(negedge clk);
      checks++; if (reg_write !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL alu_next wr %0b req %0b want 0 1", reg_write, imem_req); end
      step();
      // One cycle of ack wait before the next instruction.
    end
  endtask

  task automatic test_jmp();
    imem_ack = 1'b1; op_class = 2'b01; imm_in = 5'd10;
    step();
    imem_ack = 1'b0; imm_in = 5'd3;
    @(negedge clk);
    checks++; if (pc_src !== 2'b01 || pc_write !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL jmp_exec src %0b pcw %0b wr %0b want 01 1 0", pc_src, pc_write, reg_write); end
    checks++; if (jimm !== 5'd10) begin errors++; $display("FAIL jmp_imm got %0d want 10", jimm); end
    step();
    checks++; if (pc !== 5'd12) begin errors++; $display("FAIL jmp_pc got %0d want 12", pc); end
  endtask

  task automatic test_skip();
    // skip_cond high during FETCH must not matter.
    skip_cond = 1'b1;
    imem_ack = 1'b1; op_class = 2'b10;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0 || pc_src !== 2'b00) begin errors++; $display("FAIL skip_fetch pcw %0b src %0b want 0 00", pc_write, pc_src); end
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (pc_src !== 2'b10 || pc_write !== 1'b1) begin errors++; $display("FAIL skip_taken src %0b pcw %0b want 10 1", pc_src, pc_write); end
    step();
    checks++; if (pc !== 5'd14) begin errors++; $display("FAIL skip_taken_pc got %0d want 14", pc); end
    imem_ack = 1'b1; op_class = 2'b10;
    step();
    imem_ack = 1'b0; skip_cond = 1'b0;
    @(negedge clk);
    checks++; if (pc_src !== 2'b00 || pc_write !== 1'b1) begin errors++; $display("FAIL skip_not src %0b pcw %0b want 00 1", pc_src, pc_write); end
    step();
    checks++; if (pc !== 5'd15) begin errors++; $display("FAIL skip_not_pc got %0d want 15", pc); end
  endtask

  task automatic test_timeout();
    int pcw_seen;
    pcw_seen = 0;
    // Currently in FETCH cycle 1; 8 cycles without ack cause the fault.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pc_write) pcw_seen++;
      checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL to_wait%0d req %0b halted %0b want 1 0", i, imem_req, halted); end
      step();
    end
    @(negedge clk);
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_fault fault %0b halted %0b busy %0b want 1 1 0", fault, halted, busy); end
    checks++; if (pcw_seen !== 0 || pc !== 5'd15) begin errors++; $display("FAIL to_pc pcw %0d pc %0d want 0 15", pcw_seen, pc); end
    checks++; if (jimm !== 5'd10) begin errors++; $display("FAIL to_jimm_hold got %0d want 10", jimm); end
    step();
    run = 1'b1;
    step();
    run = 1'b0;
    @(negedge clk);
    checks++; if (fault !== 1'b0 || imem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL to_resume fault %0b req %0b halted %0b want 0 1 0", fault, imem_req, halted); end
    // Ack on the last allowed cycle is accepted.
    for (int i = 0; i < 7; i++) step();
    imem_ack = 1'b1; op_class = 2'b00;
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (pc_write !== 1'b1 || fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL to_ack_last pcw %0b fault %0b halted %0b want 1 0 0", pc_write, fault, halted); end
    step();
    checks++; if (pc !== 5'd16) begin errors++; $display("FAIL to_ack_last_pc got %0d want 16", pc); end
  endtask

  task automatic test_halt_instr();
    imem_ack = 1'b1; op_class = 2'b11;
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0 || pc_src !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL halt_exec pcw %0b src %0b busy %0b want 0 00 1", pc_write, pc_src, busy); end
    step();
    checks++; if (halted !== 1'b1 || fault !== 1'b0 || pc !== 5'd16) begin errors++; $display("FAIL halt_state halted %0b fault %0b pc %0d want 1 0 16", halted, fault, pc); end
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_async req %0b busy %0b want 0 0", imem_req, busy); end
    checks++; if (jimm !== 5'd0) begin errors++; $display("FAIL mid_rst_jimm got %0d want 0", jimm); end
    imem_ack = 1'b1;
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || ir_load !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ack req %0b ld %0b busy %0b want 0 0 0", imem_req, ir_load, busy); end
    checks++; if (instr_count !== '0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", instr_count); end
    imem_ack = 1'b0;
    step();
  endtask

  task automatic test_perf();
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; op_class = 2'b00;
      step();
      imem_ack = 1'b0;
      step();
      if (i == 0) begin
        checks++; if (instr_count !== PERF_W'(EXP_CNT1)) begin errors++; $display("FAIL perf_one got %0d want %0d", instr_count, EXP_CNT1); end
      end
    end
    checks++; if (instr_count !== PERF_W'(EXP_CNT5)) begin errors++; $display("FAIL perf_sat got %0d want %0d", instr_count, EXP_CNT5); end
    imem_ack = 1'b1; op_class = 2'b11;
    step();
    imem_ack = 1'b0;
    step();
    checks++; if (halted !== 1'b1 || instr_count !== PERF_W'(EXP_CNT5)) begin errors++; $display("FAIL perf_halt halted %0b count %0d want 1 %0d", halted, instr_count, EXP_CNT5); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jmp();
    test_skip();
    test_timeout();
    test_halt_instr();
    test_reset_mid_fetch();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
